bictr_dcnto_multi: RTL and testbench

BICTR_DCNTO_MULTI -- requirements
Module: bictr_dcnto_multi

---
 rtl/bictr_pkg.sv | 19 +
 rtl/bictr_dcnto_ch.sv | 69 ++++++
 rtl/bictr_dcnto_multi.sv | 40 ++++
 tb/tb_bictr_dcnto_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bictr_pkg.sv
// Shared definitions for the multi-channel bidirectional terminal-count counter.
package bictr_pkg;

    // Global terminal-count mode encodings; 2'b11 is reserved and behaves as FREE.
    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_STOP   = 2'b10;

    // True when the mode requests a reload at the terminal value.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

    // True when the mode requests a hold at the terminal value.
    function automatic logic is_stop(input logic [1:0] mode);
        return mode == MODE_STOP;
    endfunction

endpackage

// File: rtl/bictr_dcnto_ch.sv
// One counter channel: load, dynamic terminal compare, reload/stop action,
// terminal pulse and sticky wrap flag.
module bictr_dcnto_ch
    import bictr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             cen,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] count_to,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             ter_pulse,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] step;
    logic             at_boundary;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_pulse;
    logic             wrap_evt;

    // Zero-latency terminal compare and the candidate counting step.
    always_comb begin
        tercnt      = (count == count_to);
        step        = up_dn ? (count + ONE) : (count - ONE);
        at_boundary = up_dn ? (&count) : ~(|count);
    end

    // Next-state selection: load > terminal action > counting step > hold.
    always_comb begin
        nxt_count = count;
        nxt_pulse = 1'b0;
        wrap_evt  = 1'b0;
        if (load) begin
            nxt_count = data;
        end else if (is_reload(mode) && cen && tercnt) begin
            nxt_count = data;
        end else if (is_stop(mode) && tercnt) begin
            nxt_count = count;
        end else if (cen) begin
            nxt_count = step;
            nxt_pulse = (step == count_to);
            wrap_evt  = at_boundary;
        end
    end

    // Register count and flags; a wrap in the same cycle beats clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            ter_pulse <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            count     <= nxt_count;
            ter_pulse <= nxt_pulse;
            wrap      <= wrap_evt | (wrap & ~clr_flags);
        end
    end

endmodule

// File: rtl/bictr_dcnto_multi.sv
// NCH independent bidirectional counters sharing mode and clr_flags.
module bictr_dcnto_multi #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] data,
    input  logic [NCH-1:0]       load,
    input  logic [NCH-1:0]       cen,
    input  logic [NCH-1:0]       up_dn,
    input  logic [1:0]           mode,
    input  logic [NCH*WIDTH-1:0] count_to,
    input  logic                 clr_flags,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       tercnt,
    output logic [NCH-1:0]       ter_pulse,
    output logic [NCH-1:0]       wrap
);

    // One channel per slice; no signal crosses between channels.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        bictr_dcnto_ch #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .data      (data[i*WIDTH +: WIDTH]),
            .load      (load[i]),
            .cen       (cen[i]),
            .up_dn     (up_dn[i]),
            .mode      (mode),
            .count_to  (count_to[i*WIDTH +: WIDTH]),
            .clr_flags (clr_flags),
            .count     (count[i*WIDTH +: WIDTH]),
            .tercnt    (tercnt[i]),
            .ter_pulse (ter_pulse[i]),
            .wrap      (wrap[i])
        );
    end

endmodule

// File: tb/tb_bictr_dcnto_multi.sv
// Bench for bictr_dcnto_multi (WIDTH=4, NCH=2): arithmetic reference model,
// per-cycle compare, directed scenarios with hand-computed expectations.
module tb_bictr_dcnto_multi;

    localparam int W   = 4;
    localparam int NCH = 2;
    localparam int MOD = 1 << W;

    logic             clk;
    logic             reset;
    logic [NCH*W-1:0] data;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   cen;
    logic [NCH-1:0]   up_dn;
    logic [1:0]       mode;
    logic [NCH*W-1:0] count_to;
    logic             clr_flags;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]   tercnt;
    logic [NCH-1:0]   ter_pulse;
    logic [NCH-1:0]   wrap;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    bictr_dcnto_multi #(.WIDTH(W), .NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .load      (load),
        .cen       (cen),
        .up_dn     (up_dn),
        .mode      (mode),
        .count_to  (count_to),
        .clr_flags (clr_flags),
        .count     (count),
        .tercnt    (tercnt),
        .ter_pulse (ter_pulse),
        .wrap      (wrap)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the rules of each mode.
    int m_cnt[NCH];
    bit m_pl[NCH];
    bit m_wr[NCH];
    bit m_valid = 1'b0;
    bit done    = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            int d, ct, raw;
            bit tc, wev;
            d   = int'(data[c*W +: W]);
            ct  = int'(count_to[c*W +: W]);
            tc  = (m_cnt[c] == ct);
            wev = 1'b0;
            if (reset) begin
                m_cnt[c] = 0; m_pl[c] = 1'b0; m_wr[c] = 1'b0;
            end else begin
                m_pl[c] = 1'b0;
                if (load[c]) begin
                    m_cnt[c] = d;
                end else if (mode == 2'b01 && cen[c] && tc) begin
                    m_cnt[c] = d;
                end else if (mode == 2'b10 && tc) begin
                    m_cnt[c] = m_cnt[c];
                end else if (cen[c]) begin
                    raw      = up_dn[c] ? m_cnt[c] + 1 : m_cnt[c] - 1;
                    wev      = (raw >= MOD) || (raw < 0);
                    m_cnt[c] = (raw + MOD) % MOD;
                    m_pl[c]  = (m_cnt[c] == ct);
                end
                m_wr[c] = wev ? 1'b1 : (clr_flags ? 1'b0 : m_wr[c]);
            end
        end
        if (reset) m_valid = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare of all outputs against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        logic [NCH*W-1:0] e_cnt;
        logic [NCH-1:0]   e_tc, e_pl, e_wr;
        #1;
        if (m_valid && !done) begin
            for (int c = 0; c < NCH; c++) begin
                e_cnt[c*W +: W] = m_cnt[c][W-1:0];
                e_tc[c] = (m_cnt[c] == int'(count_to[c*W +: W]));
                e_pl[c] = m_pl[c];
                e_wr[c] = m_wr[c];
            end
            check("model_count", 32'(count), 32'(e_cnt));
            check("model_tercnt", 32'(tercnt), 32'(e_tc));
            check("model_ter_pulse", 32'(ter_pulse), 32'(e_pl));
            check("model_wrap", 32'(wrap), 32'(e_wr));
        end
    end

    // Driver: inputs change on the falling edge, one rising edge per tick.
    task automatic tick();
        @(negedge clk);
    endtask

    int pulses;

    initial begin
        reset = 1'b1; data = '0; load = '0; cen = '0; up_dn = '0;
        mode = 2'b00; clr_flags = 1'b0;
        count_to = {4'd15, 4'd5};
        tick(); tick();
        check("reset_count", 32'(count), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_pulse", 32'(ter_pulse), 32'h0);
        count_to = {4'd0, 4'd5};
        #1;
        check("reset_tercnt", 32'(tercnt), 32'b10);

        // FREE, ch0 up from 0 for 16 edges
        reset = 1'b0; cen = 2'b01; up_dn = 2'b01;
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (ter_pulse[0]) pulses++;
            if (i == 15) check("free_at15", 32'(count[3:0]), 32'd15);
        end
        check("free_wrap_to0", 32'(count[3:0]), 32'd0);
        check("free_wrap_flag", 32'(wrap), 32'b01);
        check("free_one_pulse", 32'(pulses), 32'd1);

        // clr_flags alone clears, then wrap and clear together keep the flag
        cen = 2'b00; clr_flags = 1'b1;
        tick();
        check("clr_alone", 32'(wrap), 32'b00);
        cen = 2'b01; up_dn = 2'b00;
        tick();
        check("wrap_down_15", 32'(count[3:0]), 32'd15);
        check("wrap_beats_clr", 32'(wrap), 32'b01);
        cen = 2'b00;
        tick();
        check("clr_again", 32'(wrap), 32'b00);
        clr_flags = 1'b0;

        // RELOAD, ch1 down from 9 to 2 then reload
        mode = 2'b01; data = {4'd9, 4'd0}; count_to = {4'd2, 4'd5};
        load = 2'b10;
        tick();
        check("reload_load9", 32'(count[7:4]), 32'd9);
        load = 2'b00; cen = 2'b10; up_dn = 2'b00;
        for (int v = 8; v >= 2; v--) exp_q.push_back(4'(v));
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd8);
        pulses = 0;
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            tick();
            if (ter_pulse[1]) pulses++;
            check("reload_seq", 32'(count[7:4]), 32'(e));
        end
        check("reload_one_pulse", 32'(pulses), 32'd1);
        check("reload_no_wrap", 32'(wrap[1]), 32'd0);

        // STOP, ch0 up from 3 to 6, then count_to moves to 8
        cen = 2'b00; mode = 2'b10; data = {4'd9, 4'd3}; load = 2'b01;
        tick();
        check("stop_load3", 32'(count[3:0]), 32'd3);
        load = 2'b00; count_to = {4'd2, 4'd6}; cen = 2'b01; up_dn = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        check("stop_hold6", 32'(count[3:0]), 32'd6);
        count_to = {4'd2, 4'd8};
        tick(); tick();
        check("stop_resume8", 32'(count[3:0]), 32'd8);
        tick();
        check("stop_hold8", 32'(count[3:0]), 32'd8);

        // Reset mid-count in STOP with tercnt=1 overrides a load
        reset = 1'b1; load = 2'b01; data = {4'd9, 4'd12};
        tick();
        check("midreset_count", 32'(count), 32'h0);
        check("midreset_flags", 32'({ter_pulse, wrap}), 32'h0);
        reset = 1'b0; load = 2'b00;
        tick();
        check("post_reset_step", 32'(count[3:0]), 32'd1);

        // load with cen, data equal to count_to: no pulse
        mode = 2'b00; data = {4'd9, 4'd12}; count_to = {4'd2, 4'd12};
        load = 2'b01; cen = 2'b01;
        tick();
        check("load_over_cen", 32'(count[3:0]), 32'd12);
        check("load_no_pulse", 32'(ter_pulse[0]), 32'd0);
        check("load_tercnt", 32'(tercnt[0]), 32'd1);
        load = 2'b00;
        tick();
        check("free_after_load", 32'(count[3:0]), 32'd13);
        count_to = {4'd2, 4'd13};
        #1;
        check("tercnt_same_cycle", 32'(tercnt[0]), 32'd1);
        cen = 2'b00;
        tick();

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
